gobou_ctrl_layer: RTL and testbench

GOBOU_CTRL_LAYER -- requirements
Module: gobou_ctrl_layer

---
 rtl/gobou_ctrl_layer_pkg.sv | 19 +
 rtl/gobou_ctrl_counter.sv | 41 ++++
 rtl/gobou_ctrl_layer.sv | 167 ++++++++++++++++
 tb/tb_gobou_ctrl_layer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/gobou_ctrl_layer_pkg.sv
// Shared constants and types for the GOBOU layer controller.
package gobou_ctrl_layer_pkg;

  localparam int unsigned GOBOU_CORE  = 8;   // MAC lanes per group
  localparam int unsigned GOBOU_D_MAC = 2;   // MAC/accumulator pipeline latency
  localparam int unsigned IMG_AW      = 12;  // image / output address width
  localparam int unsigned NET_AW      = 14;  // network (weight/bias) address width
  localparam int unsigned CNT_W       = 10;  // input/output count width
  localparam int unsigned LANE_W      = 3;   // lane index width
  localparam int unsigned PROD_W      = 20;  // width of address products

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_BIAS = 2'd2,
    S_OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/gobou_ctrl_counter.sv
// Loadable up-counter that wraps to zero after reaching max_val; last flags cnt == max_val.
module gobou_ctrl_counter
  import gobou_ctrl_layer_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise step and wrap at max.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == max_val);

endmodule

// File: rtl/gobou_ctrl_layer.sv
// Layer sequencer: per group of CORE outputs, accumulate total_in inputs, add bias,
// drain the MAC pipeline, then write the group's outputs.
module gobou_ctrl_layer
  import gobou_ctrl_layer_pkg::*;
#(
  parameter int unsigned CORE  = GOBOU_CORE,
  parameter int unsigned D_MAC = GOBOU_D_MAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              cfg_relu,
  input  logic [CNT_W-1:0]  total_in,
  input  logic [CNT_W-1:0]  total_out,
  input  logic [IMG_AW-1:0] img_offset,
  input  logic [NET_AW-1:0] net_offset,
  input  logic [IMG_AW-1:0] out_offset,
  output logic              ack,
  output logic [IMG_AW-1:0] img_addr,
  output logic [NET_AW-1:0] net_addr,
  output logic              mac_clear,
  output logic              mac_valid,
  output logic              bias_en,
  output logic              relu_en,
  output logic              out_we,
  output logic [IMG_AW-1:0] out_addr,
  output logic [LANE_W-1:0] out_lane
);

  state_e            state_q, state_d;
  logic              zero_q, zero_d;  // one-cycle busy after an empty job
  logic              relu_q, relu_d;
  logic [CNT_W-1:0]  tin_q, tin_d, tout_q, tout_d;
  logic [IMG_AW-1:0] img_off_q, img_off_d, out_off_q, out_off_d;
  logic [NET_AW-1:0] net_off_q, net_off_d;

  logic accept, job_ok;
  logic [CNT_W-1:0] i_cnt, d_cnt, k_cnt, g_cnt;
  logic             i_last, d_last, k_last, g_last;
  logic [CNT_W-1:0] i_max, d_max, k_max, g_max;
  logic [CNT_W:0]   grp_cnt;
  logic [PROD_W-1:0] base_out, rem, prod_w, prod_b;

  assign accept = (state_q == S_IDLE) && !zero_q && req;
  assign job_ok = (total_in != '0) && (total_out != '0);

  // Loop bounds derived from the latched job.
  always_comb begin
    grp_cnt  = ({1'b0, tout_q} + (CNT_W+1)'(CORE - 1)) / (CNT_W+1)'(CORE);
    base_out = PROD_W'(g_cnt) * PROD_W'(CORE);
    rem      = PROD_W'(tout_q) - base_out;
    prod_w   = PROD_W'(g_cnt) * PROD_W'(tin_q);
    prod_b   = PROD_W'(grp_cnt) * PROD_W'(tin_q);
    i_max    = tin_q - CNT_W'(1);
    d_max    = CNT_W'(D_MAC);
    k_max    = (rem >= PROD_W'(CORE)) ? CNT_W'(CORE - 1) : CNT_W'(rem - PROD_W'(1));
    g_max    = CNT_W'(grp_cnt - (CNT_W+1)'(1));
  end

  gobou_ctrl_counter #(.W(CNT_W)) u_cnt_i (
    .clk(clk), .rst(rst), .load(accept), .load_val('0), .en(state_q == S_ACC),
    .max_val(i_max), .cnt(i_cnt), .last(i_last)
  );
  gobou_ctrl_counter #(.W(CNT_W)) u_cnt_d (
    .clk(clk), .rst(rst), .load(accept), .load_val('0), .en(state_q == S_BIAS),
    .max_val(d_max), .cnt(d_cnt), .last(d_last)
  );
  gobou_ctrl_counter #(.W(CNT_W)) u_cnt_k (
    .clk(clk), .rst(rst), .load(accept), .load_val('0), .en(state_q == S_OUT),
    .max_val(k_max), .cnt(k_cnt), .last(k_last)
  );
  gobou_ctrl_counter #(.W(CNT_W)) u_cnt_g (
    .clk(clk), .rst(rst), .load(accept), .load_val('0), .en((state_q == S_OUT) && k_last),
    .max_val(g_max), .cnt(g_cnt), .last(g_last)
  );

  // Next state and config capture; config only changes on an accepted request.
  always_comb begin
    state_d   = state_q;
    zero_d    = 1'b0;
    relu_d    = relu_q;
    tin_d     = tin_q;
    tout_d    = tout_q;
    img_off_d = img_off_q;
    net_off_d = net_off_q;
    out_off_d = out_off_q;
    if (accept) begin
      relu_d    = cfg_relu;
      tin_d     = total_in;
      tout_d    = total_out;
      img_off_d = img_offset;
      net_off_d = net_offset;
      out_off_d = out_offset;
    end
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (job_ok) state_d = S_ACC;
          else        zero_d  = 1'b1;
        end
      end
      S_ACC:   if (i_last) state_d = S_BIAS;
      S_BIAS:  if (d_last) state_d = S_OUT;
      S_OUT:   if (k_last) state_d = g_last ? S_IDLE : S_ACC;
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      zero_q    <= 1'b0;
      relu_q    <= 1'b0;
      tin_q     <= '0;
      tout_q    <= '0;
      img_off_q <= '0;
      net_off_q <= '0;
      out_off_q <= '0;
    end else begin
      state_q   <= state_d;
      zero_q    <= zero_d;
      relu_q    <= relu_d;
      tin_q     <= tin_d;
      tout_q    <= tout_d;
      img_off_q <= img_off_d;
      net_off_q <= net_off_d;
      out_off_q <= out_off_d;
    end
  end

  // Output decode from registered state/counters only; req never reaches a strobe.
  always_comb begin
    ack       = (state_q == S_IDLE) && !zero_q;
    img_addr  = '0;
    net_addr  = '0;
    mac_clear = 1'b0;
    mac_valid = 1'b0;
    bias_en   = 1'b0;
    relu_en   = 1'b0;
    out_we    = 1'b0;
    out_addr  = '0;
    out_lane  = '0;
    case (state_q)
      S_ACC: begin
        mac_valid = 1'b1;
        mac_clear = (i_cnt == '0);
        img_addr  = img_off_q + IMG_AW'(i_cnt);
        net_addr  = NET_AW'(PROD_W'(net_off_q) + prod_w + PROD_W'(i_cnt));
      end
      S_BIAS: begin
        if (d_cnt == '0) begin
          bias_en  = 1'b1;
          net_addr = NET_AW'(PROD_W'(net_off_q) + prod_b + PROD_W'(g_cnt));
        end
      end
      S_OUT: begin
        out_we   = 1'b1;
        relu_en  = relu_q;
        out_lane = k_cnt[LANE_W-1:0];
        out_addr = IMG_AW'(PROD_W'(out_off_q) + base_out + PROD_W'(k_cnt));
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gobou_ctrl_layer.sv
// Scoreboard bench for gobou_ctrl_layer (CORE=8, D_MAC=2).
module tb_gobou_ctrl_layer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        cfg_relu;
  logic [9:0]  total_in, total_out;
  logic [11:0] img_offset, out_offset;
  logic [13:0] net_offset;
  logic        ack;
  logic [11:0] img_addr, out_addr;
  logic [13:0] net_addr;
  logic        mac_clear, mac_valid, bias_en, relu_en, out_we;
  logic [2:0]  out_lane;

  gobou_ctrl_layer dut (
    .clk(clk), .rst(rst), .req(req), .cfg_relu(cfg_relu),
    .total_in(total_in), .total_out(total_out),
    .img_offset(img_offset), .net_offset(net_offset), .out_offset(out_offset),
    .ack(ack), .img_addr(img_addr), .net_addr(net_addr),
    .mac_clear(mac_clear), .mac_valid(mac_valid), .bias_en(bias_en), .relu_en(relu_en),
    .out_we(out_we), .out_addr(out_addr), .out_lane(out_lane)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  stb;   // {mac_valid, bias_en, out_we}
    logic        mc;
    logic [11:0] img;
    logic [13:0] net;
    logic [11:0] oa;
    logic [2:0]  lane;
    logic        relu;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  task automatic push(input logic [2:0] stb, input logic mc, input int img, input int net,
                      input int oa, input int lane, input logic relu);
    rec_t r;
    r.stb = stb; r.mc = mc; r.img = 12'(img); r.net = 14'(net);
    r.oa = 12'(oa); r.lane = 3'(lane); r.relu = relu;
    exp_q.push_back(r);
  endtask

  // Reference event list for one job.
  task automatic push_model(input int ti, input int to, input logic relu,
                            input int img, input int net, input int outo);
    int groups, n;
    groups = (to + 7) / 8;
    for (int g = 0; g < groups; g++) begin
      for (int i = 0; i < ti; i++) push(3'b100, i == 0, img + i, net + g * ti + i, 0, 0, 1'b0);
      push(3'b010, 1'b0, 0, net + groups * ti + g, 0, 0, 1'b0);
      n = (to - g * 8 < 8) ? to - g * 8 : 8;
      for (int k = 0; k < n; k++) push(3'b001, 1'b0, 0, 0, outo + g * 8 + k, k, relu);
    end
  endtask

  // Monitor: every strobe cycle pops one expected event; other cycles must be quiet.
  always @(negedge clk) begin
    rec_t obs;
    rec_t e;
    obs.stb = {mac_valid, bias_en, out_we};
    obs.mc = mac_clear; obs.img = img_addr; obs.net = net_addr;
    obs.oa = out_addr; obs.lane = out_lane; obs.relu = relu_en;
    if (obs.stb != 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(obs), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("strobe_event", 64'(obs), 64'(e));
      end
    end else begin
      check("quiet_cycle", 64'(obs), 64'(0));
    end
  end

  // Issue a job from the current (between-edges) point and time its busy window.
  task automatic run_job(input int ti, input int to, input logic relu, input int img,
                         input int net, input int outo, input bit pulse, input int exp_len);
    int cnt;
    bit done;
    cfg_relu = relu; total_in = 10'(ti); total_out = 10'(to);
    img_offset = 12'(img); net_offset = 14'(net); out_offset = 12'(outo);
    req = 1'b1;
    cnt = 0;
    done = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (ack) begin
        done = 1'b1;
        break;
      end
      cnt++;
      if (pulse) begin
        // Keep requesting with unrelated config; the running job must not notice.
        req = 1'b1;
        cfg_relu = ~cfg_relu;
        total_in = 10'($urandom_range(1, 40));
        total_out = 10'($urandom_range(1, 40));
        img_offset = 12'($urandom); net_offset = 14'($urandom); out_offset = 12'($urandom);
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
    check("ack_returned", 64'(done), 64'(1));
    check("ack_low_cycles", 64'(cnt), 64'(exp_len));
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; cfg_relu = 1'b0; total_in = '0; total_out = '0;
    img_offset = '0; net_offset = '0; out_offset = '0;
    repeat (2) @(negedge clk);
    check("reset_ack", 64'(ack), 64'(1));
    check("reset_outputs", {img_addr, net_addr, out_addr, out_lane,
                            mac_clear, mac_valid, bias_en, relu_en, out_we}, 64'(0));
    #2 rst = 1'b0;

    // Single group, ReLU on; accepted on the first edge after reset.
    for (int i = 0; i < 4; i++) push(3'b100, i == 0, 10 + i, 20 + i, 0, 0, 1'b0);
    push(3'b010, 1'b0, 0, 24, 0, 0, 1'b0);
    for (int k = 0; k < 8; k++) push(3'b001, 1'b0, 0, 0, 30 + k, k, 1'b1);
    run_job(4, 8, 1'b1, 10, 20, 30, 1'b0, 15);

    // Two groups, second group partial (2 lanes).
    push_model(3, 10, 1'b0, 50, 100, 200);
    run_job(3, 10, 1'b0, 50, 100, 200, 1'b0, 22);

    // Empty jobs: one busy cycle, no strobes.
    run_job(0, 5, 1'b1, 1, 2, 3, 1'b0, 1);
    run_job(3, 0, 1'b1, 1, 2, 3, 1'b0, 1);

    // Output address wrap, ReLU off.
    push(3'b100, 1'b1, 0, 0, 0, 0, 1'b0);
    push(3'b010, 1'b0, 0, 1, 0, 0, 1'b0);
    push(3'b001, 1'b0, 0, 0, 4094, 0, 1'b0);
    push(3'b001, 1'b0, 0, 0, 4095, 1, 1'b0);
    push(3'b001, 1'b0, 0, 0, 0, 2, 1'b0);
    push(3'b001, 1'b0, 0, 0, 1, 3, 1'b0);
    run_job(1, 4, 1'b0, 0, 0, 4094, 1'b0, 8);

    // req held every cycle during the job.
    push_model(2, 9, 1'b1, 7, 300, 40);
    run_job(2, 9, 1'b1, 7, 300, 40, 1'b1, 19);

    // Weight/bias address wrap across three groups.
    push_model(3, 17, 1'b1, 4090, 16380, 4000);
    run_job(3, 17, 1'b1, 4090, 16380, 4000, 1'b0, 35);

    // Reset in the middle of accumulation.
    push_model(6, 8, 1'b1, 0, 0, 0);
    cfg_relu = 1'b1; total_in = 10'd6; total_out = 10'd8;
    img_offset = '0; net_offset = '0; out_offset = '0;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_ack", 64'(ack), 64'(1));
    check("midreset_outputs", {img_addr, net_addr, out_addr, out_lane,
                               mac_clear, mac_valid, bias_en, relu_en, out_we}, 64'(0));
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    push_model(5, 3, 1'b0, 60, 70, 80);
    run_job(5, 3, 1'b0, 60, 70, 80, 1'b0, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
